// File: rtl/msx_slot_expander.sv
// MSX primary/secondary slot decoder with page-table address translation and
// a req/ack memory sequencer that stretches the CPU cycle with wait.
module msx_slot_expander #(
  parameter int          ADDR_W   = 25,
  parameter int          TO_W     = 8,
  parameter int          TIMEOUT  = 200,
  parameter logic [7:0]  PSL_PORT = 8'hA8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        expanded,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_mreq,
  input  logic              cpu_iorq,
  input  logic              cpu_m1,
  output logic [7:0]        cpu_din,
  output logic              cpu_wait,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [ADDR_W-13:0] cfg_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err,
  output logic [1:0]        active_slot,
  output logic [1:0]        active_subslot
);

  localparam int              BASE_W  = ADDR_W - 14;
  localparam int              ENTRY_W = ADDR_W - 12;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Slot registers and page table storage
  logic [7:0]         psl;
  logic [7:0]         ssl [4];
  logic [63:0]        entry_valid;
  logic [ENTRY_W-2:0] page_store [64];

  logic [TO_W-1:0]    to_cnt;

  // Decode helpers
  logic [1:0]         page;
  logic [7:0]         sub_byte;
  logic [5:0]         entry_idx;
  logic [ENTRY_W-2:0] entry_word;
  logic               entry_ok;
  logic               entry_writable;
  logic [BASE_W-1:0]  entry_base;
  logic [1:0]         ssl_slot;
  logic               ssl_hit;
  logic               psl_hit;
  logic               mem_cycle;
  logic               start;
  logic               timeout_hit;

  assign page = cpu_addr[15:14];

  // Resolve which primary slot and effective subslot the current page maps to
  always_comb begin
    active_slot    = psl[{page, 1'b0} +: 2];
    sub_byte       = ssl[active_slot];
    active_subslot = expanded[active_slot] ? sub_byte[{page, 1'b0} +: 2] : 2'b00;
  end

  assign entry_idx      = {active_slot, active_subslot, page};
  assign entry_ok       = entry_valid[entry_idx];
  assign entry_word     = page_store[entry_idx];
  assign entry_writable = entry_word[ENTRY_W-2];
  assign entry_base     = entry_word[BASE_W-1:0];

  // FFFFh always lies in page 3, so the subslot register belongs to psl[7:6]
  assign ssl_slot    = psl[7:6];
  assign ssl_hit     = cpu_mreq & (cpu_addr == 16'hFFFF) & expanded[ssl_slot];
  assign psl_hit     = cpu_iorq & ~cpu_m1 & (cpu_addr[7:0] == PSL_PORT);
  assign mem_cycle   = cpu_mreq & (cpu_rd | cpu_wr) & ~ssl_hit;
  // rd and wr together count as a write, so writability gates on cpu_wr alone
  assign start       = mem_cycle & entry_ok & (~cpu_wr | entry_writable);
  assign timeout_hit = (to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus handshake outputs; wait rises combinationally on detect
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    cpu_wait   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          cpu_wait   = ~reset;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        cpu_wait = 1'b1;
        if (mem_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!cpu_mreq || !(cpu_rd || cpu_wr)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Primary slot register: writable whenever no memory access is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psl <= 8'h00;
    end else if (psl_hit && cpu_wr && state != REQ) begin
      psl <= cpu_dout;
    end
  end

  // Subslot registers, one per primary slot, written through FFFFh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        ssl[i] <= 8'h00;
      end
    end else if (state == IDLE && ssl_hit && cpu_wr) begin
      ssl[ssl_slot] <= cpu_dout;
    end
  end

  // Valid bits live in flops so reset can invalidate the whole table at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_valid <= '0;
    end else if (cfg_we) begin
      entry_valid[cfg_addr] <= cfg_data[ENTRY_W-1];
    end
  end

  // Writable flag and base are kept in plain RAM without reset
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      page_store[cfg_addr] <= cfg_data[ENTRY_W-2:0];
    end
  end

  // Access datapath: latch the request on detect, return read data or abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      cpu_din     <= 8'hFF;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (psl_hit && cpu_rd) begin
            cpu_din <= psl;
          end else if (ssl_hit && cpu_rd && !cpu_wr) begin
            cpu_din <= ~ssl[ssl_slot];
          end else if (mem_cycle && !entry_ok && !cpu_wr) begin
            cpu_din <= 8'hFF;
          end
          if (start) begin
            mem_addr  <= {entry_base, cpu_addr[13:0]};
            mem_we    <= cpu_wr;
            mem_wdata <= cpu_dout;
            to_cnt    <= '0;
          end
        end
        REQ: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (mem_ack) begin
            if (!mem_we) begin
              cpu_din <= mem_rdata;
            end
          end else if (timeout_hit) begin
            cpu_din     <= 8'hFF;
            timeout_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msx_slot_expander.sv
// Testbench for msx_slot_expander: directed scenarios then randomized
// accesses compared against a transaction-level model of the slot rules.
module tb_msx_slot_expander;

  localparam int ADDR_W  = 25;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 10;
  localparam int BASE_W  = ADDR_W - 14;

  logic              clk;
  logic              reset;
  logic [3:0]        expanded;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              cpu_mreq;
  logic              cpu_iorq;
  logic              cpu_m1;
  logic [7:0]        cpu_din;
  logic              cpu_wait;
  logic              cfg_we;
  logic [5:0]        cfg_addr;
  logic [ADDR_W-13:0] cfg_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              timeout_err;
  logic [1:0]        active_slot;
  logic [1:0]        active_subslot;

  msx_slot_expander #(
    .ADDR_W  (ADDR_W),
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT),
    .PSL_PORT(8'hA8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .expanded      (expanded),
    .cpu_addr      (cpu_addr),
    .cpu_dout      (cpu_dout),
    .cpu_rd        (cpu_rd),
    .cpu_wr        (cpu_wr),
    .cpu_mreq      (cpu_mreq),
    .cpu_iorq      (cpu_iorq),
    .cpu_m1        (cpu_m1),
    .cpu_din       (cpu_din),
    .cpu_wait      (cpu_wait),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .timeout_err   (timeout_err),
    .active_slot   (active_slot),
    .active_subslot(active_subslot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]        m_psl;
  logic [7:0]        m_ssl [4];
  bit                m_valid [64];
  bit                m_wrt [64];
  logic [BASE_W-1:0] m_base [64];
  logic [3:0]        m_exp;
  logic [7:0]        m_din;
  bit                m_terr;

  int checks = 0;
  int errors = 0;

  int                last_req;
  int                last_wait;
  logic [ADDR_W-1:0] last_addr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_psl  = 8'h00;
    for (int i = 0; i < 4; i++) m_ssl[i] = 8'h00;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_din  = 8'hFF;
    m_terr = 1'b0;
  endtask

  function automatic logic [1:0] mSlot(input logic [1:0] pg);
    return m_psl[int'(pg) * 2 +: 2];
  endfunction

  function automatic logic [1:0] mSub(input logic [1:0] pg);
    logic [1:0] s;
    s = mSlot(pg);
    return m_exp[s] ? m_ssl[s][int'(pg) * 2 +: 2] : 2'b00;
  endfunction

  task automatic cfgWrite(input logic [5:0] idx, input bit v, input bit w, input logic [BASE_W-1:0] b);
    @(posedge clk); #1;
    cfg_we   = 1'b1;
    cfg_addr = idx;
    cfg_data = {v, w, b};
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_valid[idx] = v;
    m_wrt[idx]   = w;
    m_base[idx]  = b;
  endtask

  task automatic setExpanded(input logic [3:0] e);
    @(posedge clk); #1;
    expanded = e;
    m_exp    = e;
  endtask

  task automatic ioAccess(input logic [7:0] port, input bit wr, input logic [7:0] d, input bit m1);
    @(posedge clk); #1;
    cpu_addr = {8'h00, port};
    cpu_iorq = 1'b1;
    cpu_m1   = m1;
    cpu_wr   = wr;
    cpu_rd   = !wr;
    cpu_dout = d;
    @(posedge clk); #1;
    cpu_iorq = 1'b0;
    cpu_m1   = 1'b0;
    cpu_wr   = 1'b0;
    cpu_rd   = 1'b0;
    if (port == 8'hA8 && !m1) begin
      if (wr) m_psl = d;
      else    m_din = m_psl;
    end
    @(negedge clk);
    checkOutput("io_din", cpu_din, m_din);
  endtask

  task automatic decodeCheck(input logic [15:0] a);
    @(posedge clk); #1;
    cpu_addr = a;
    @(negedge clk);
    checkOutput("dec_slot", active_slot, mSlot(a[15:14]));
    checkOutput("dec_sub", active_subslot, mSub(a[15:14]));
  endtask

  // One CPU memory cycle; ack_delay counts REQ cycles before ack, 0 = never
  task automatic memAccess(input logic [15:0] a, input bit rd, input bit wr, input logic [7:0] d,
                           input int ack_delay, input logic [7:0] rdata,
                           input bit rewrite, input logic [BASE_W-1:0] new_base);
    logic [1:0]        pg;
    logic [1:0]        slot;
    logic [1:0]        sub;
    logic [5:0]        idx;
    bit                ssl_acc;
    bit                go;
    bit                acked;
    bit                done;
    int                exp_req;
    int                req_cnt;
    int                wait_cnt;
    logic [ADDR_W-1:0] exp_addr;
    pg       = a[15:14];
    slot     = mSlot(pg);
    sub      = mSub(pg);
    idx      = {slot, sub, pg};
    ssl_acc  = (a == 16'hFFFF) && m_exp[slot];
    go       = !ssl_acc && m_valid[idx] && (!wr || m_wrt[idx]);
    acked    = (ack_delay >= 1) && (ack_delay <= TIMEOUT);
    exp_req  = go ? (acked ? ack_delay : TIMEOUT) : 0;
    exp_addr = {m_base[idx], a[13:0]};
    if (ssl_acc) begin
      if (wr) m_ssl[slot] = d;
      else    m_din = ~m_ssl[slot];
    end else if (!m_valid[idx]) begin
      if (!wr) m_din = 8'hFF;
    end else if (go) begin
      if (!acked) begin
        m_din  = 8'hFF;
        m_terr = 1'b1;
      end else if (!wr) begin
        m_din = rdata;
      end
    end

    @(posedge clk); #1;
    cpu_addr = a;
    cpu_mreq = 1'b1;
    cpu_rd   = rd;
    cpu_wr   = wr;
    cpu_dout = d;
    @(negedge clk);
    checkOutput("act_slot", active_slot, slot);
    checkOutput("act_sub", active_subslot, sub);
    checkOutput("wait_detect", cpu_wait, go);
    checkOutput("req_detect", mem_req, 1'b0);
    wait_cnt = cpu_wait ? 1 : 0;
    req_cnt  = 0;
    if (go) begin
      done = 1'b0;
      for (int c = 0; c < 4 * TIMEOUT + 20 && !done; c++) begin
        @(posedge clk); #1;
        mem_ack = 1'b0;
        cfg_we  = 1'b0;
        @(negedge clk);
        if (cpu_wait) wait_cnt++;
        if (mem_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            last_addr = mem_addr;
            checkOutput("mem_addr", mem_addr, exp_addr);
            checkOutput("mem_we", mem_we, wr);
            if (wr) checkOutput("mem_wdata", mem_wdata, d);
            if (rewrite) begin
              cfg_we      = 1'b1;
              cfg_addr    = idx;
              cfg_data    = {m_valid[idx], m_wrt[idx], new_base};
              m_base[idx] = new_base;
            end
          end
          if (req_cnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
          end
        end else begin
          done = 1'b1;
        end
      end
      checkOutput("req_bound", done, 1'b1);
      checkOutput("addr_held", mem_addr, exp_addr);
    end
    @(posedge clk); #1;
    cpu_mreq = 1'b0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    @(negedge clk);
    checkOutput("req_cycles", req_cnt, exp_req);
    checkOutput("wait_cycles", wait_cnt, go ? exp_req + 1 : 0);
    checkOutput("cpu_din", cpu_din, m_din);
    checkOutput("timeout_err", timeout_err, m_terr);
    checkOutput("idle_req", mem_req, 1'b0);
    last_req  = req_cnt;
    last_wait = wait_cnt;
    @(posedge clk);
  endtask

  task automatic applyStimulus(input int n);
    int op;
    int rw;
    int ack;
    for (int i = 0; i < 64; i++) begin
      cfgWrite(6'(i), ($urandom % 4) != 0, $urandom % 2, BASE_W'($urandom_range(0, 2047)));
    end
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        cfgWrite(6'($urandom), ($urandom % 4) != 0, $urandom % 2, BASE_W'($urandom_range(0, 2047)));
      end else if (op == 1) begin
        ioAccess((($urandom % 5) == 0) ? 8'($urandom) : 8'hA8, $urandom % 2, 8'($urandom),
                 ($urandom % 8) == 0);
      end else if (op == 2) begin
        setExpanded(4'($urandom));
      end else begin
        rw  = $urandom_range(1, 3);
        ack = (($urandom % 6) == 0) ? 0 : $urandom_range(1, TIMEOUT);
        memAccess((($urandom % 6) == 0) ? 16'hFFFF : 16'($urandom), rw[0], rw[1], 8'($urandom),
                  ack, 8'($urandom), ($urandom % 4) == 0, BASE_W'($urandom_range(0, 2047)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    expanded  = 4'b0000;
    cpu_addr  = 16'h0000;
    cpu_dout  = 8'h00;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_mreq  = 1'b0;
    cpu_iorq  = 1'b0;
    cpu_m1    = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 6'd0;
    cfg_data  = '0;
    mem_rdata = 8'h00;
    mem_ack   = 1'b0;
    m_exp     = 4'b0000;
    for (int i = 0; i < 64; i++) begin
      m_wrt[i]  = 1'b0;
      m_base[i] = '0;
    end
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_din", cpu_din, 8'hFF);
    checkOutput("rst_wait", cpu_wait, 1'b0);
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 8'h00);
    checkOutput("rst_terr", timeout_err, 1'b0);
    checkOutput("rst_slot", active_slot, 2'd0);

    // Basic translated read with a three-cycle ack
    ioAccess(8'hA8, 1'b1, 8'hF0, 1'b0);
    cfgWrite(6'd51, 1'b1, 1'b1, 11'h012);
    memAccess(16'hC123, 1'b1, 1'b0, 8'h00, 3, 8'h5A, 1'b0, '0);
    checkOutput("plan_addr", last_addr, 25'h48123);
    checkOutput("plan_wait", last_wait, 4);
    checkOutput("plan_din", cpu_din, 8'h5A);

    // Subslot register in slot 3
    setExpanded(4'b1000);
    ioAccess(8'hA8, 1'b1, 8'hC0, 1'b0);
    memAccess(16'hFFFF, 1'b0, 1'b1, 8'hE4, 3, 8'h00, 1'b0, '0);
    checkOutput("ssl_wr_noreq", last_req, 0);
    memAccess(16'hFFFF, 1'b1, 1'b0, 8'h00, 3, 8'h00, 1'b0, '0);
    checkOutput("ssl_rd_din", cpu_din, 8'h1B);
    decodeCheck(16'hC000);
    checkOutput("p3_sub", active_subslot, 2'd3);
    decodeCheck(16'h0000);
    checkOutput("p0_sub_slot0", active_subslot, 2'd0);
    ioAccess(8'hA8, 1'b1, 8'hC3, 1'b0);
    decodeCheck(16'h0000);
    checkOutput("p0_slot3", active_slot, 2'd3);
    ioAccess(8'hA8, 1'b1, 8'hC0, 1'b0);
    ioAccess(8'hA8, 1'b1, 8'h55, 1'b1);

    // Non-writable entry and invalid entry
    cfgWrite(6'd1, 1'b1, 1'b0, 11'h005);
    memAccess(16'h4000, 1'b0, 1'b1, 8'hAA, 1, 8'h00, 1'b0, '0);
    checkOutput("ro_noreq", last_req, 0);
    checkOutput("ro_nowait", last_wait, 0);
    memAccess(16'h8000, 1'b1, 1'b0, 8'h00, 1, 8'h33, 1'b0, '0);
    checkOutput("inv_din", cpu_din, 8'hFF);

    // Timeout, recovery, and ack coinciding with the timeout
    cfgWrite(6'd63, 1'b1, 1'b1, 11'h155);
    memAccess(16'hC010, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0, '0);
    checkOutput("to_req_len", last_req, TIMEOUT);
    checkOutput("to_din", cpu_din, 8'hFF);
    checkOutput("to_err", timeout_err, 1'b1);
    memAccess(16'hC020, 1'b1, 1'b0, 8'h00, 2, 8'h77, 1'b0, '0);
    checkOutput("after_to_din", cpu_din, 8'h77);
    checkOutput("err_sticky", timeout_err, 1'b1);
    memAccess(16'hC024, 1'b1, 1'b0, 8'h00, TIMEOUT, 8'h3C, 1'b0, '0);
    checkOutput("ack_at_to", cpu_din, 8'h3C);
    memAccess(16'hC028, 1'b1, 1'b1, 8'h99, 1, 8'h00, 1'b0, '0);

    // Table rewrite while the access is in flight
    memAccess(16'hC030, 1'b1, 1'b0, 8'h00, 4, 8'h66, 1'b1, 11'h2AA);
    checkOutput("rw_inflight", last_addr, {11'h155, 14'h0030});
    memAccess(16'hC034, 1'b1, 1'b0, 8'h00, 1, 8'h11, 1'b0, '0);
    checkOutput("rw_next", last_addr, {11'h2AA, 14'h0034});

    // Reset in the middle of a request
    @(posedge clk); #1;
    cpu_addr = 16'hC040;
    cpu_mreq = 1'b1;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_req", mem_req, 1'b1);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_req_drop", mem_req, 1'b0);
    checkOutput("rst_wait_drop", cpu_wait, 1'b0);
    cpu_mreq = 1'b0;
    cpu_rd   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 8'h42;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_req", mem_req, 1'b0);
    checkOutput("late_ack_din", cpu_din, 8'hFF);
    checkOutput("late_ack_terr", timeout_err, 1'b0);
    ioAccess(8'hA8, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_psl", cpu_din, 8'h00);
    memAccess(16'hC040, 1'b1, 1'b0, 8'h00, 1, 8'h42, 1'b0, '0);
    checkOutput("rst_table_inv", last_req, 0);

    applyStimulus(120);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
